// File: rtl/pc_gen_pkg.sv
// Shared constants for the PC generation stage: parameter defaults, state
// encoding and redirect-source identifiers.
package pc_gen_pkg;

  localparam int          ADDR_W_DEF     = 64;
  localparam logic [63:0] START_ADDR_DEF = 64'h0000_0000_8000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Redirect sources, listed from highest to lowest priority.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_TRAP = 2'd1;
  localparam logic [1:0] SRC_MRET = 2'd2;
  localparam logic [1:0] SRC_BR   = 2'd3;

  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational arbiter picking the winning redirect (trap > mret > branch)
// and flagging a misaligned winner.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  input  logic              mret_valid_i,
  input  logic [ADDR_W-1:0] mret_target_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_target_o,
  output logic              misaligned_o
);

  logic [1:0] src_s;

  // Priority encode the redirect sources.
  always_comb begin
    src_s = SRC_NONE;
    if (trap_valid_i) begin
      src_s = SRC_TRAP;
    end else if (mret_valid_i) begin
      src_s = SRC_MRET;
    end else if (br_valid_i) begin
      src_s = SRC_BR;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Route the winner's target; only that target is alignment-checked.
  always_comb begin
    redirect_valid_o  = 1'b1;
    redirect_target_o = {ADDR_W{1'b0}};
    case (src_s)
      SRC_TRAP: redirect_target_o = trap_target_i;
      SRC_MRET: redirect_target_o = mret_target_i;
      SRC_BR:   redirect_target_o = br_target_i;
      default:  redirect_valid_o  = 1'b0;
    endcase
    misaligned_o = redirect_valid_o & addr_misaligned(redirect_target_o[1:0]);
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation stage: holds the fetch PC, offers it to fetch
// over valid/ready, and applies redirects, halt and misalignment stops.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  input  logic              mret_valid_i,
  input  logic [ADDR_W-1:0] mret_target_i,
  input  logic              halt_i,
  output logic              halted_o,
  output logic              misalign_o,
  output logic [63:0]       fetch_cnt_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [63:0]       cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              misalign_q, misalign_d;

  logic              handshake_s;
  logic              redir_valid_s;
  logic [ADDR_W-1:0] redir_target_s;
  logic              redir_misaligned_s;

  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .trap_valid_i     (trap_valid_i),
    .trap_target_i    (trap_target_i),
    .mret_valid_i     (mret_valid_i),
    .mret_target_i    (mret_target_i),
    .br_valid_i       (br_valid_i),
    .br_target_i      (br_target_i),
    .redirect_valid_o (redir_valid_s),
    .redirect_target_o(redir_target_s),
    .misaligned_o     (redir_misaligned_s)
  );

  // valid_q mirrors state RUN, so the handshake uses only registered state.
  assign handshake_s = valid_q & ready_i;

  // Next-state logic for state, PC, counter and status flags.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (handshake_s) begin
          cnt_d = cnt_q + 64'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (halt_i) begin
          state_d = ST_HALT;
        end else if (redir_valid_s) begin
          if (redir_misaligned_s) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d = redir_target_s;
          end
        end else if (handshake_s) begin
          pc_d = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    valid_d  = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= START_ADDR;
      cnt_q      <= 64'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign halted_o    = halted_q;
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = cnt_q;

endmodule
